// File: rtl/game_pkg.sv
// game_pkg: shared round states, winner codes and score helpers for the match controller
package game_pkg;
    localparam int SCORE_W = 5;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        PLAY       = 3'd2,
        HIT_PAUSE  = 3'd3,
        MATCH_OVER = 3'd4
    } round_state_t;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] max);
        return (s < max) ? s + SCORE_W'(1) : s;
    endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: counts frame ticks while enabled; done flags the tick that reaches terminal
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic         done
);
    logic [W-1:0] count;
    assign done = enable & tick & (count == terminal - W'(1));
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clear) count <= '0;
        else if (enable & tick) count <= done ? '0 : count + W'(1);
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: match-level FSM owning scores, countdown, freeze and respawn/clear pulses
module round_sequencer
    import game_pkg::*;
#(
    parameter int WIN_SCORE        = 10,
    parameter int COUNT_START      = 3,
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int HIT_PAUSE_FRAMES = 90
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               start_req,
    input  logic               player_1_hit,
    input  logic               player_2_hit,
    output logic               freeze,
    output logic               respawn,
    output logic               clear_bullets,
    output logic [SCORE_W-1:0] player_1_score,
    output logic [SCORE_W-1:0] player_2_score,
    output logic [3:0]         countdown_digit,
    output logic [1:0]         winner,
    output logic [2:0]         state_out
);
    localparam int MAX_FRAMES = (COUNTDOWN_FRAMES > HIT_PAUSE_FRAMES) ? COUNTDOWN_FRAMES : HIT_PAUSE_FRAMES;
    localparam int TW = $clog2(MAX_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
    localparam logic [3:0] DIGIT0 = 4'(COUNT_START);

    round_state_t       state, state_n;
    logic               start_q, start_rise, done;
    logic               respawn_n, clear_n;
    logic [SCORE_W-1:0] p1_n, p2_n;
    logic [3:0]         digit_n;
    logic [1:0]         winner_n;

    assign start_rise = start_req & ~start_q;
    assign freeze     = state != PLAY;
    assign state_out  = state;

    // one timer serves both the countdown digits and the post-hit pause
    frame_timer #(.W(TW)) u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .tick     (frame_tick),
        .clear    (state_n != state),
        .enable   (state == COUNTDOWN || state == HIT_PAUSE),
        .terminal (state == HIT_PAUSE ? TW'(HIT_PAUSE_FRAMES) : TW'(COUNTDOWN_FRAMES)),
        .done     (done)
    );

    always_comb begin
        state_n   = state;
        p1_n      = player_1_score;
        p2_n      = player_2_score;
        digit_n   = countdown_digit;
        winner_n  = winner;
        respawn_n = 1'b0;
        clear_n   = 1'b0;
        case (state)
            IDLE, MATCH_OVER: if (start_rise) begin
                state_n   = COUNTDOWN;
                p1_n      = '0;
                p2_n      = '0;
                winner_n  = WIN_NONE;
                digit_n   = DIGIT0;
                respawn_n = 1'b1;
                clear_n   = 1'b1;
            end
            COUNTDOWN: if (done) begin
                digit_n = countdown_digit - 4'd1;
                if (countdown_digit == 4'd1) state_n = PLAY;
            end
            PLAY: if (player_1_hit | player_2_hit) begin
                p1_n     = player_2_hit ? sat_inc(player_1_score, WIN) : player_1_score;
                p2_n     = player_1_hit ? sat_inc(player_2_score, WIN) : player_2_score;
                clear_n  = 1'b1;
                winner_n = ((p1_n == WIN) ? WIN_P1 : WIN_NONE) | ((p2_n == WIN) ? WIN_P2 : WIN_NONE);
                state_n  = (p1_n == WIN || p2_n == WIN) ? MATCH_OVER : HIT_PAUSE;
            end
            HIT_PAUSE: if (done) begin
                state_n   = COUNTDOWN;
                digit_n   = DIGIT0;
                respawn_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state           <= IDLE;
            start_q         <= 1'b0;
            player_1_score  <= '0;
            player_2_score  <= '0;
            countdown_digit <= '0;
            winner          <= WIN_NONE;
            respawn         <= 1'b0;
            clear_bullets   <= 1'b0;
        end else begin
            state           <= state_n;
            start_q         <= start_req;
            player_1_score  <= p1_n;
            player_2_score  <= p2_n;
            countdown_digit <= digit_n;
            winner          <= winner_n;
            respawn         <= respawn_n;
            clear_bullets   <= clear_n;
        end
endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Match-level controller for the two-player shooter. It sequences the game through idle, pre-round countdown, live play, post-hit pause and match-over. It owns both player scores and issues freeze, respawn and bullet-clear commands to the player and bullet blocks. The existing hit detector only reports hits; this block decides what each hit means.

Parameters:
WIN_SCORE, 10, score at which the match ends (1..31)
COUNT_START, 3, first countdown digit shown (1..9)
COUNTDOWN_FRAMES, 60, frame ticks per countdown digit (>=1)
HIT_PAUSE_FRAMES, 90, frame ticks of freeze after a scoring hit (>=1)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-Clk pulse per video frame, already synchronous to Clk
start_req  in  1  level start request (key/keycode); block detects rising edge
player_1_hit  in  1  one-cycle pulse: player 1 was struck
player_2_hit  in  1  one-cycle pulse: player 2 was struck
freeze  out  1  1 = players and bullets must not move
respawn  out  1  one-cycle pulse: players return to spawn positions
clear_bullets  out  1  one-cycle pulse: bullets removed
player_1_score  out  5  player 1 score
player_2_score  out  5  player 2 score
countdown_digit  out  4  current countdown digit, 0 outside COUNTDOWN
winner  out  2  00 none, 01 P1, 10 P2, 11 draw
state_out  out  3  encoded current state, for debug and LEDs

Behaviour:
- Reset (async, any time, including mid-round):
  - state IDLE; scores 0; winner 00; countdown_digit 0; freeze 1; respawn 0; clear_bullets 0; internal timers 0; start edge register 0.
- Start edge: start_rise = start_req & ~start_q, where start_q is registered each Clk.
- States:
  - IDLE (freeze=1): on start_rise, next cycle enter COUNTDOWN. Scores and winner clear, digit=COUNT_START, timer=0. respawn and clear_bullets pulse high for that first COUNTDOWN cycle.
  - COUNTDOWN (freeze=1): each frame_tick increments timer.
    - When a tick arrives with timer==COUNTDOWN_FRAMES-1: timer returns to 0 and the digit decrements.
    - If the digit was 1 at that point, enter PLAY with digit 0.
    - Ticks with no tick present leave all state unchanged.
  - PLAY (freeze=0): hits are sampled every Clk.
    - player_1_hit alone: P2 score +1.
    - player_2_hit alone: P1 score +1.
    - Both in the same cycle: both scores +1.
    - Scores saturate at WIN_SCORE.
    - Any hit: clear_bullets pulses the following cycle. Next state is MATCH_OVER if either updated score equals WIN_SCORE, otherwise HIT_PAUSE with timer=0.
  - HIT_PAUSE (freeze=1): counts HIT_PAUSE_FRAMES ticks. On the terminal tick, enter COUNTDOWN with digit=COUNT_START, timer=0, and a respawn pulse.
  - MATCH_OVER (freeze=1):
    - winner is set on entry: 01 if only P1 reached WIN_SCORE, 10 if only P2, 11 if both reached it in the same cycle.
    - Scores and winner hold.
    - start_rise behaves as in IDLE (clear, countdown, respawn and clear_bullets pulse).
- Hit pulses outside PLAY are ignored: no score change, no pulse.
- start_rise outside IDLE and MATCH_OVER is ignored.
- A frame_tick coinciding with a hit in PLAY has no effect on timers.
- Pulse outputs are registered and high exactly 1 Clk. Latency from input event to state/score change is 1 Clk.
- state_out encoding: IDLE 0, COUNTDOWN 1, PLAY 2, HIT_PAUSE 3, MATCH_OVER 4.

Decomposition:
- Package game_pkg holds:
  - enum round_state_t (3-bit, encoding above)
  - winner constants WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW
  - SCORE_W=5
- One sub-module, frame_timer:
  - loadable counter of frame_tick pulses with terminal-count parameter
  - inputs: clear, enable; output: done (combinational, tick & terminal)
  - instantiated once and shared by COUNTDOWN and HIT_PAUSE.

Test Plan:
(Bench parameters: WIN_SCORE=3, COUNT_START=3, COUNTDOWN_FRAMES=2, HIT_PAUSE_FRAMES=3; frame_tick every 4 Clk.)
- Reset then start_req held high 10 cycles -> exactly one respawn pulse; state 1, digit 3; digit goes 3->2->1 every 2 ticks; after 6 ticks state 2, digit 0, freeze 0.
- In PLAY, player_1_hit pulse -> P2 score 1, clear_bullets high 1 cycle, state 3; after 3 ticks state 1 with respawn pulse, digit 3.
- player_1_hit and player_2_hit in the same cycle at scores 2/2 -> both scores 3, state 4, winner 11, freeze 1.
- P1 scores 3 hits with P2 at 0 -> winner 01, state 4; further hit pulses leave scores at 3/0.
- Hit pulses during COUNTDOWN and HIT_PAUSE -> scores unchanged, no clear_bullets pulse.
- Reset asserted mid-HIT_PAUSE with scores 2/1 -> immediately state 0, scores 0/0, winner 00, freeze 1; start edge in MATCH_OVER restarts with scores 0.
